// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer read/write schedulers.
package fb_pkg;

   localparam int FB_ADDR_W = 10;
   localparam int FB_DATA_W = 16;

   localparam logic OWNER_DISP = 1'b0;
   localparam logic OWNER_HOST = 1'b1;

   // One in-flight RAM access: does it carry data, and who gets it
   typedef struct packed {
      logic valid;
      logic owner;
   } tag_t;

endpackage

// File: rtl/fb_read_tag_pipe.sv
// Delay line that follows each RAM access for RD_LATENCY cycles so the
// returning data can be steered to its owner. Async reset drops all tags.
import fb_pkg::*;

module fb_read_tag_pipe #(
   parameter int RD_LATENCY = 1
) (
   input  logic clk_in,
   input  logic reset,
   input  tag_t tag_in,
   output tag_t tag_out
);

   tag_t stages [RD_LATENCY];

   // shift tags one stage per cycle; stage RD_LATENCY-1 lines up with RAM data
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RD_LATENCY; i++) stages[i] <= '0;
      end else begin
         stages[0] <= tag_in;
         for (int i = 1; i < RD_LATENCY; i++) stages[i] <= stages[i-1];
      end
   end

   assign tag_out = stages[RD_LATENCY-1];

endmodule

// File: rtl/fb_read_scheduler.sv
// Arbitrates the single framebuffer read port between display pixel fetch
// (absolute priority) and host readback, and owns the front/back buffer
// select with swaps deferred to frame_start.
import fb_pkg::*;

module fb_read_scheduler #(
   parameter int ADDR_W       = FB_ADDR_W,
   parameter int DATA_W       = FB_DATA_W,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 255
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_data_valid,
   input  logic              frame_start,
   input  logic              host_req_valid,
   input  logic [ADDR_W-1:0] host_req_addr,
   output logic              host_req_ready,
   output logic              host_rsp_valid,
   output logic [DATA_W-1:0] host_rsp_data,
   input  logic              swap_req,
   output logic              swap_pending,
   output logic              buffer_select,
   output logic              host_starved,
   output logic              ram_rd_en,
   output logic [ADDR_W:0]   ram_rd_addr,
   input  logic [DATA_W-1:0] ram_rd_data
);

   localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

   logic              host_gnt;
   logic              host_busy_q;
   logic              bsel_q;
   logic              pending_q;
   logic [7:0]        starve_q;
   logic [ADDR_W:0]   addr_q;
   logic [DATA_W-1:0] disp_q;
   logic [DATA_W-1:0] host_q;
   tag_t              tag_in;
   tag_t              tag_out;

   // per-cycle grant: display wins outright, host only when the port is idle
   always_comb begin
      host_req_ready = !disp_req && !host_busy_q;
      host_gnt       = host_req_valid && host_req_ready;
      ram_rd_en      = disp_req || host_gnt;
      ram_rd_addr    = addr_q;
      tag_in         = '0;
      if (disp_req) begin
         ram_rd_addr  = {bsel_q, disp_addr};
         tag_in.valid = 1'b1;
         tag_in.owner = OWNER_DISP;
      end else if (host_gnt) begin
         ram_rd_addr  = {~bsel_q, host_req_addr};
         tag_in.valid = 1'b1;
         tag_in.owner = OWNER_HOST;
      end
   end

   // keep the last issued address on the bus while the port is idle
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset)          addr_q <= '0;
      else if (ram_rd_en) addr_q <= ram_rd_addr;
   end

   // single outstanding host read: busy from grant until its response cycle
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset)               host_busy_q <= 1'b0;
      else if (host_gnt)       host_busy_q <= 1'b1;
      else if (host_rsp_valid) host_busy_q <= 1'b0;
   end

   // buffer swap only lands on a frame boundary; repeated requests collapse
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         bsel_q    <= 1'b0;
         pending_q <= 1'b0;
      end else if (frame_start && pending_q) begin
         bsel_q    <= ~bsel_q;
         pending_q <= 1'b0;
      end else if (swap_req) begin
         pending_q <= 1'b1;
      end
   end

   // count cycles the host is held off; status only, does not alter priority
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset)                          starve_q <= '0;
      else if (!host_req_valid || host_gnt) starve_q <= '0;
      else if (starve_q != STARVE_MAX)    starve_q <= starve_q + 8'd1;
   end

   fb_read_tag_pipe #(
      .RD_LATENCY (RD_LATENCY)
   ) u_tag_pipe (
      .clk_in  (clk_in),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign disp_data_valid = tag_out.valid && (tag_out.owner == OWNER_DISP);
   assign host_rsp_valid  = tag_out.valid && (tag_out.owner == OWNER_HOST);

   // capture returning data so each output holds its last word between reads
   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         disp_q <= '0;
         host_q <= '0;
      end else begin
         if (disp_data_valid) disp_q <= ram_rd_data;
         if (host_rsp_valid)  host_q <= ram_rd_data;
      end
   end

   assign disp_data     = disp_data_valid ? ram_rd_data : disp_q;
   assign host_rsp_data = host_rsp_valid  ? ram_rd_data : host_q;
   assign swap_pending  = pending_q;
   assign buffer_select = bsel_q;
   assign host_starved  = (starve_q == STARVE_MAX);

endmodule

// File: tb/tb_fb_read_scheduler.sv
// Directed bench for fb_read_scheduler with a RAM model and a scoreboard
// of expected (cycle, data) pairs per requester.
module tb_fb_read_scheduler;

   localparam int LAT   = 2;
   localparam int LIMIT = 16;

   logic        clk_in;
   logic        reset;
   logic        disp_req;
   logic [9:0]  disp_addr;
   logic [15:0] disp_data;
   logic        disp_data_valid;
   logic        frame_start;
   logic        host_req_valid;
   logic [9:0]  host_req_addr;
   logic        host_req_ready;
   logic        host_rsp_valid;
   logic [15:0] host_rsp_data;
   logic        swap_req;
   logic        swap_pending;
   logic        buffer_select;
   logic        host_starved;
   logic        ram_rd_en;
   logic [10:0] ram_rd_addr;
   logic [15:0] ram_rd_data;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } exp_t;

   exp_t dq[$];
   exp_t hq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   host_seen = 0;
   int   seen0;
   logic bsel_m;
   logic [15:0] rpipe [LAT];

   fb_read_scheduler #(
      .ADDR_W(10), .DATA_W(16), .RD_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
   ) dut (
      .clk_in(clk_in), .reset(reset),
      .disp_req(disp_req), .disp_addr(disp_addr),
      .disp_data(disp_data), .disp_data_valid(disp_data_valid),
      .frame_start(frame_start),
      .host_req_valid(host_req_valid), .host_req_addr(host_req_addr),
      .host_req_ready(host_req_ready),
      .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
      .swap_req(swap_req), .swap_pending(swap_pending),
      .buffer_select(buffer_select), .host_starved(host_starved),
      .ram_rd_en(ram_rd_en), .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
   );

   function automatic logic [15:0] ram_word(input logic [10:0] a);
      return {a[4:0], a} ^ 16'hA55A;
   endfunction

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc++;

   // RAM model: data for the address strobed LAT cycles earlier
   always @(posedge clk_in) begin
      rpipe[0] <= ram_rd_en ? ram_word(ram_rd_addr) : 16'hDEAD;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
   end
   assign ram_rd_data = rpipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step();
         disp_req = 1'b0; host_req_valid = 1'b0;
         swap_req = 1'b0; frame_start = 1'b0;
      end
   endtask

   // response monitor: every valid must match the head of its queue
   always @(negedge clk_in) begin
      exp_t e;
      if (disp_data_valid === 1'b1) begin
         chk("disp_expected", 32'(dq.size() != 0), 32'd1);
         if (dq.size() != 0) begin
            e = dq.pop_front();
            chk("disp_cycle", cyc, e.cyc);
            chk("disp_data", 32'(disp_data), 32'(e.data));
         end
      end
      if (host_rsp_valid === 1'b1) begin
         host_seen++;
         chk("host_expected", 32'(hq.size() != 0), 32'd1);
         if (hq.size() != 0) begin
            e = hq.pop_front();
            chk("host_cycle", cyc, e.cyc);
            chk("host_data", 32'(host_rsp_data), 32'(e.data));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; disp_req = 1'b0; disp_addr = '0; frame_start = 1'b0;
      host_req_valid = 1'b0; host_req_addr = '0; swap_req = 1'b0;
      bsel_m = 1'b0;
      #12;
      chk("rst_disp_valid", 32'(disp_data_valid), 32'd0);
      chk("rst_host_valid", 32'(host_rsp_valid), 32'd0);
      chk("rst_ready", 32'(host_req_ready), 32'd1);
      chk("rst_bsel", 32'(buffer_select), 32'd0);
      chk("rst_pending", 32'(swap_pending), 32'd0);
      chk("rst_starved", 32'(host_starved), 32'd0);
      chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
      chk("rst_rd_addr", 32'(ram_rd_addr), 32'd0);
      step(); reset = 1'b0;
      idle(2);

      // 64-pixel display row, no bubbles expected
      for (int i = 0; i < 64; i++) begin
         step();
         disp_req = 1'b1; disp_addr = 10'(i);
         dq.push_back('{cyc + LAT, ram_word({bsel_m, 10'(i)})});
         @(negedge clk_in);
         chk("burst_rd_en", 32'(ram_rd_en), 32'd1);
         chk("burst_rd_addr", 32'(ram_rd_addr), 32'({bsel_m, 10'(i)}));
      end
      step(); disp_req = 1'b0;
      @(negedge clk_in);
      chk("idle_rd_en", 32'(ram_rd_en), 32'd0);
      chk("idle_addr_hold", 32'(ram_rd_addr), 32'({bsel_m, 10'd63}));
      idle(LAT + 2);

      // single host read from the back buffer
      step(); host_req_valid = 1'b1; host_req_addr = 10'h123;
      hq.push_back('{cyc + LAT, ram_word({~bsel_m, 10'h123})});
      @(negedge clk_in);
      chk("host_ready", 32'(host_req_ready), 32'd1);
      chk("host_rd_addr", 32'(ram_rd_addr), 32'({~bsel_m, 10'h123}));
      step(); host_req_valid = 1'b0;
      for (int k = 1; k <= LAT; k++) begin
         if (k > 1) step();
         @(negedge clk_in);
         chk("host_busy_ready", 32'(host_req_ready), 32'd0);
      end
      step();
      @(negedge clk_in);
      chk("host_ready_back", 32'(host_req_ready), 32'd1);
      idle(2);

      // host held off by a full display row; starvation flag
      for (int j = 0; j < 64; j++) begin
         step();
         disp_req = 1'b1; disp_addr = 10'(j + 100);
         host_req_valid = 1'b1; host_req_addr = 10'h055;
         dq.push_back('{cyc + LAT, ram_word({bsel_m, 10'(j + 100)})});
         @(negedge clk_in);
         chk("starve_ready", 32'(host_req_ready), 32'd0);
         chk("starve_flag", 32'(host_starved), 32'(j >= LIMIT));
      end
      step(); disp_req = 1'b0;
      hq.push_back('{cyc + LAT, ram_word({~bsel_m, 10'h055})});
      @(negedge clk_in);
      chk("starve_gnt_ready", 32'(host_req_ready), 32'd1);
      chk("starve_gnt_addr", 32'(ram_rd_addr), 32'({~bsel_m, 10'h055}));
      chk("starve_gnt_flag", 32'(host_starved), 32'd1);
      step(); host_req_valid = 1'b0;
      @(negedge clk_in);
      chk("starve_cleared", 32'(host_starved), 32'd0);
      idle(LAT + 2);

      // swap request deferred to frame_start
      step(); swap_req = 1'b1;
      step(); swap_req = 1'b0;
      @(negedge clk_in);
      chk("swap_pending_set", 32'(swap_pending), 32'd1);
      chk("swap_bsel_hold", 32'(buffer_select), 32'd0);
      idle(10);
      @(negedge clk_in);
      chk("swap_pending_hold", 32'(swap_pending), 32'd1);
      step(); frame_start = 1'b1; disp_req = 1'b1; disp_addr = 10'd7;
      dq.push_back('{cyc + LAT, ram_word({bsel_m, 10'd7})});
      @(negedge clk_in);
      chk("swap_old_buf_addr", 32'(ram_rd_addr), 32'({1'b0, 10'd7}));
      step(); frame_start = 1'b0; bsel_m = 1'b1; disp_addr = 10'd8;
      dq.push_back('{cyc + LAT, ram_word({bsel_m, 10'd8})});
      @(negedge clk_in);
      chk("swap_new_buf_addr", 32'(ram_rd_addr), 32'({1'b1, 10'd8}));
      chk("swap_bsel", 32'(buffer_select), 32'd1);
      chk("swap_pending_clr", 32'(swap_pending), 32'd0);
      step(); disp_req = 1'b0; host_req_valid = 1'b1; host_req_addr = 10'h2AA;
      hq.push_back('{cyc + LAT, ram_word({~bsel_m, 10'h2AA})});
      @(negedge clk_in);
      chk("swap_host_addr", 32'(ram_rd_addr), 32'({1'b0, 10'h2AA}));
      step(); host_req_valid = 1'b0;
      idle(LAT + 2);

      // swap_req coincident with frame_start while idle is deferred
      step(); swap_req = 1'b1; frame_start = 1'b1;
      step(); swap_req = 1'b0; frame_start = 1'b0;
      @(negedge clk_in);
      chk("coinc_bsel", 32'(buffer_select), 32'd1);
      chk("coinc_pending", 32'(swap_pending), 32'd1);
      step(); frame_start = 1'b1;
      step(); frame_start = 1'b0; bsel_m = 1'b0;
      @(negedge clk_in);
      chk("coinc_toggle", 32'(buffer_select), 32'(bsel_m));
      chk("coinc_pending_clr", 32'(swap_pending), 32'd0);

      // two requests before one frame_start give one toggle
      step(); swap_req = 1'b1;
      step(); swap_req = 1'b0;
      step(); swap_req = 1'b1;
      step(); swap_req = 1'b0;
      step(); frame_start = 1'b1;
      step(); frame_start = 1'b0; bsel_m = 1'b1;
      @(negedge clk_in);
      chk("dbl_toggle", 32'(buffer_select), 32'(bsel_m));
      step(); frame_start = 1'b1;
      step(); frame_start = 1'b0;
      @(negedge clk_in);
      chk("dbl_no_accum", 32'(buffer_select), 32'(bsel_m));
      idle(2);

      // reset with a host read in flight: response must be dropped
      step(); host_req_valid = 1'b1; host_req_addr = 10'h0F0;
      @(negedge clk_in);
      chk("inflight_gnt", 32'(host_req_ready), 32'd1);
      seen0 = host_seen;
      step(); host_req_valid = 1'b0; reset = 1'b1;
      @(negedge clk_in);
      chk("midrst_ready", 32'(host_req_ready), 32'd1);
      chk("midrst_bsel", 32'(buffer_select), 32'd0);
      chk("midrst_pending", 32'(swap_pending), 32'd0);
      step(); reset = 1'b0; bsel_m = 1'b0;
      idle(LAT + 3);
      chk("midrst_no_rsp", 32'(host_seen), 32'(seen0));
      @(negedge clk_in);
      chk("post_rst_ready", 32'(host_req_ready), 32'd1);

      chk("disp_queue_drained", 32'(dq.size()), 32'd0);
      chk("host_queue_drained", 32'(hq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
